id_ex_skid: RTL and testbench
=============================

ID_EX_SKID -- requirements
Module: id_ex_skid

Interface
REQ-001 Parameter XLEN, 32, operand width of n1/n2.
REQ-002 Parameter OPW, 7, opcode (t) width.
REQ-003 Parameter RAW, 5, destination register address width.
REQ-004 Parameter ZERO_X0, 1, when 1 the write enable is suppressed for address 0.
REQ-005 Port list:
- clk  in  1  single clock; all state updates on posedge clk.
- rst  in  1  reset, synchronous, active-high.
- flush  in  1  kill all held entries and the current input.
- id_valid  in  1  upstream entry present.
- id_ready  out  1  block can accept an entry this cycle.
- id_t  in  OPW  opcode; 0 means bubble.
- id_st  in  3  sub-type.
- id_sst  in  1  sub-sub-type.
- id_n1, id_n2  in  XLEN  operands.
- id_wa  in  RAW  destination address.
- id_we  in  1  destination write enable.
- ex_valid  out  1  entry presented to EX.
- ex_ready  in  1  EX consumes the entry this cycle.
- ex_t, ex_st, ex_sst, ex_n1, ex_n2, ex_wa, ex_we  out  same widths as id_*  presented entry.
- occ  out  2  entries held (0..2).

Function
REQ-006 Storage: two payload slots, MAIN (drives ex_*) and SKID; FIFO order; state EMPTY (occ 0), ONE (occ 1), FULL (occ 2).
REQ-007 Accept = id_valid & id_ready & ~flush; an accepted entry with id_t==0 is dropped (handshake completes, nothing stored).
REQ-008 Consume = ex_valid & ex_ready.
REQ-009 id_ready = (state != FULL), derived from registers only; no combinational path from ex_ready or id_valid to id_ready.
REQ-010 ex_valid = (state != EMPTY), registered.
REQ-011 Transitions (no flush): EMPTY + store -> ONE; ONE + store & ~consume -> FULL (entry to SKID); ONE + store & consume -> ONE (entry to MAIN); ONE + consume & ~store -> EMPTY; FULL + consume -> ONE (SKID moves to MAIN); FULL and no consume -> hold.
REQ-012 Latency: entry accepted in cycle N appears on ex_* with ex_valid=1 in cycle N+1 when state was EMPTY, or ONE with consume.
REQ-013 Throughput: with ex_ready held 1, one entry per cycle, no bubbles inserted.
REQ-014 Stall: while ex_valid=1 and ex_ready=0, all ex_* outputs hold stable.
REQ-015 When ex_valid=0, ex_t, ex_st, ex_sst, ex_n1, ex_n2, ex_wa, ex_we all read 0.
REQ-016 With ZERO_X0=1, stored we = id_we & (id_wa != 0); with ZERO_X0=0, we stored unchanged.
REQ-017 Flush: next cycle state EMPTY, occ=0, all outputs 0; flush overrides simultaneous accept and consume; id_ready in the flush cycle follows REQ-009.
REQ-018 occ equals state encoding at all times.

Reset
REQ-019 On rst=1 at posedge clk: state EMPTY, both slots cleared to 0, ex_valid=0, all ex_* outputs 0, occ=0; id_ready=1 from the following cycle.
REQ-020 rst has priority over flush, accept and consume; reset mid-operation discards all held entries.

Structure
REQ-021 Shared package id_ex_pkg holds: OP_NOP (0) constant, default widths (XLEN, OPW, RAW), 2-bit state encoding EMPTY/ONE/FULL.
REQ-022 Payload slot is a sub-module id_ex_slot (parametrised register with load and clear); id_ex_skid instantiates two.

Verification
REQ-023 Streaming: ex_ready=1, send t=0x33,n1=5,n2=7,wa=3,we=1 then t=0x13,n1=9 back-to-back -> ex_* shows each one cycle after accept, ex_valid continuous, occ stays 1.
REQ-024 Backpressure: ex_ready=0, send three entries t=0x33,0x13,0x03 -> first two accepted, id_ready=0 after second, occ=2, ex_* holds t=0x33; raise ex_ready -> 0x33, 0x13, then 0x03 emerge in order.
REQ-025 Bubble: id_valid=1, id_t=0, n1=0xFFFFFFFF -> id_ready stays 1, occ unchanged, ex_valid stays 0, ex_n1 reads 0.
REQ-026 x0 suppression: t=0x33, wa=0, we=1 -> ex_we=0 (ZERO_X0=1); same with ZERO_X0=0 -> ex_we=1.
REQ-027 Flush: occ=2 plus simultaneous id_valid with t=0x63, flush=1 -> next cycle occ=0, ex_valid=0, all ex_* 0, 0x63 never appears.
REQ-028 Reset mid-stall: occ=2, rst=1 for one cycle -> outputs 0, occ=0, id_ready=1 the cycle after.

Source files
------------

// File: rtl/id_ex_pkg.sv
// Shared constants for the ID->EX skid buffer: default widths, the bubble
// opcode and the 2-bit occupancy/state encoding.
package id_ex_pkg;

    localparam int XLEN_DEF = 32;
    localparam int OPW_DEF  = 7;
    localparam int RAW_DEF  = 5;

    // Opcode value that marks a bubble; such entries are never stored.
    localparam int OP_NOP = 0;

    typedef logic [1:0] occ_t;

    // State encoding doubles as the occupancy count driven on occ.
    localparam logic [1:0] ST_EMPTY = 2'd0;
    localparam logic [1:0] ST_ONE   = 2'd1;
    localparam logic [1:0] ST_FULL  = 2'd2;

endpackage

// File: rtl/id_ex_slot.sv
// Single payload register with synchronous clear (clear wins over load).
module id_ex_slot #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         clr,
    input  logic         ld,
    input  logic [W-1:0] d,
    output logic [W-1:0] q
);

    always_ff @(posedge clk) begin
        if (rst || clr) begin
            q <= '0;
        end else if (ld) begin
            q <= d;
        end
    end

endmodule

// File: rtl/id_ex_skid.sv
// Two-entry ID->EX pipeline register with skid slot. id_ready depends only
// on registered state, so ex_ready never reaches the upstream handshake.
//
// Handshake: a transfer happens on a posedge where valid and ready are both 1;
// valid never depends on ready, and ready never depends on valid in the same cycle.
module id_ex_skid
    import id_ex_pkg::*;
#(
    parameter int XLEN    = XLEN_DEF,
    parameter int OPW     = OPW_DEF,
    parameter int RAW     = RAW_DEF,
    parameter int ZERO_X0 = 1
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            flush,
    input  logic            id_valid,
    output logic            id_ready,
    input  logic [OPW-1:0]  id_t,
    input  logic [2:0]      id_st,
    input  logic            id_sst,
    input  logic [XLEN-1:0] id_n1,
    input  logic [XLEN-1:0] id_n2,
    input  logic [RAW-1:0]  id_wa,
    input  logic            id_we,
    output logic            ex_valid,
    input  logic            ex_ready,
    output logic [OPW-1:0]  ex_t,
    output logic [2:0]      ex_st,
    output logic            ex_sst,
    output logic [XLEN-1:0] ex_n1,
    output logic [XLEN-1:0] ex_n2,
    output logic [RAW-1:0]  ex_wa,
    output logic            ex_we,
    output logic [1:0]      occ
);

    localparam int PW = OPW + 3 + 1 + 2 * XLEN + RAW + 1;

    logic [1:0]    state;
    logic [1:0]    state_nxt;
    logic          store;
    logic          consume;
    logic          we_in;
    logic [PW-1:0] in_payload;
    logic [PW-1:0] main_d;
    logic [PW-1:0] main_q;
    logic [PW-1:0] skid_q;
    logic          main_ld;
    logic          main_clr;
    logic          main_sel_skid;
    logic          skid_ld;
    logic          skid_clr;

    assign id_ready = (state != ST_FULL);
    assign ex_valid = (state != ST_EMPTY);
    assign occ      = state;

    // Writes to x0 are architecturally void, so drop the enable at the source.
    assign we_in      = id_we & ((ZERO_X0 == 0) || (id_wa != '0));
    assign in_payload = {id_t, id_st, id_sst, id_n1, id_n2, id_wa, we_in};

    assign store   = id_valid & id_ready & ~flush & (id_t != OPW'(OP_NOP));
    assign consume = ex_valid & ex_ready;

    always_comb begin
        state_nxt     = state;
        main_ld       = 1'b0;
        main_clr      = 1'b0;
        main_sel_skid = 1'b0;
        skid_ld       = 1'b0;
        skid_clr      = 1'b0;
        if (flush) begin
            state_nxt = ST_EMPTY;
            main_clr  = 1'b1;
            skid_clr  = 1'b1;
        end else begin
            case (state)
                ST_EMPTY: begin
                    if (store) begin
                        state_nxt = ST_ONE;
                        main_ld   = 1'b1;
                    end
                end
                ST_ONE: begin
                    if (store && !consume) begin
                        state_nxt = ST_FULL;
                        skid_ld   = 1'b1;
                    end else if (store && consume) begin
                        main_ld = 1'b1;
                    end else if (consume) begin
                        // Clearing MAIN keeps ex_* at zero while nothing is presented.
                        state_nxt = ST_EMPTY;
                        main_clr  = 1'b1;
                    end
                end
                ST_FULL: begin
                    if (consume) begin
                        state_nxt     = ST_ONE;
                        main_ld       = 1'b1;
                        main_sel_skid = 1'b1;
                        skid_clr      = 1'b1;
                    end
                end
                default: begin
                    state_nxt = ST_EMPTY;
                    main_clr  = 1'b1;
                    skid_clr  = 1'b1;
                end
            endcase
        end
    end

    assign main_d = main_sel_skid ? skid_q : in_payload;

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= ST_EMPTY;
        end else begin
            state <= state_nxt;
        end
    end

    id_ex_slot #(.W(PW)) u_main (
        .clk (clk),
        .rst (rst),
        .clr (main_clr),
        .ld  (main_ld),
        .d   (main_d),
        .q   (main_q)
    );

    id_ex_slot #(.W(PW)) u_skid (
        .clk (clk),
        .rst (rst),
        .clr (skid_clr),
        .ld  (skid_ld),
        .d   (in_payload),
        .q   (skid_q)
    );

    assign {ex_t, ex_st, ex_sst, ex_n1, ex_n2, ex_wa, ex_we} = main_q;

endmodule

// File: tb/tb_id_ex_skid.sv
// Bench for id_ex_skid: directed scenarios plus random traffic, both checked
// against a two-deep FIFO model; a second instance covers ZERO_X0=0.
module tb_id_ex_skid;

    typedef struct packed {
        logic [6:0]  t;
        logic [2:0]  st;
        logic        sst;
        logic [31:0] n1;
        logic [31:0] n2;
        logic [4:0]  wa;
        logic        we;
    } ent_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        flush = 1'b0;
    logic        id_valid = 1'b0;
    logic [6:0]  id_t = '0;
    logic [2:0]  id_st = '0;
    logic        id_sst = 1'b0;
    logic [31:0] id_n1 = '0;
    logic [31:0] id_n2 = '0;
    logic [4:0]  id_wa = '0;
    logic        id_we = 1'b0;
    logic        ex_ready = 1'b0;

    logic        id_ready, ex_valid, ex_sst, ex_we;
    logic [6:0]  ex_t;
    logic [2:0]  ex_st;
    logic [31:0] ex_n1, ex_n2;
    logic [4:0]  ex_wa;
    logic [1:0]  occ;

    logic        id_ready0, ex_valid0, ex_sst0, ex_we0;
    logic [6:0]  ex_t0;
    logic [2:0]  ex_st0;
    logic [31:0] ex_n10, ex_n20;
    logic [4:0]  ex_wa0;
    logic [1:0]  occ0;

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    id_ex_skid dut (
        .clk(clk), .rst(rst), .flush(flush),
        .id_valid(id_valid), .id_ready(id_ready),
        .id_t(id_t), .id_st(id_st), .id_sst(id_sst),
        .id_n1(id_n1), .id_n2(id_n2), .id_wa(id_wa), .id_we(id_we),
        .ex_valid(ex_valid), .ex_ready(ex_ready),
        .ex_t(ex_t), .ex_st(ex_st), .ex_sst(ex_sst),
        .ex_n1(ex_n1), .ex_n2(ex_n2), .ex_wa(ex_wa), .ex_we(ex_we),
        .occ(occ)
    );

    id_ex_skid #(.ZERO_X0(0)) dut0 (
        .clk(clk), .rst(rst), .flush(flush),
        .id_valid(id_valid), .id_ready(id_ready0),
        .id_t(id_t), .id_st(id_st), .id_sst(id_sst),
        .id_n1(id_n1), .id_n2(id_n2), .id_wa(id_wa), .id_we(id_we),
        .ex_valid(ex_valid0), .ex_ready(ex_ready),
        .ex_t(ex_t0), .ex_st(ex_st0), .ex_sst(ex_sst0),
        .ex_n1(ex_n10), .ex_n2(ex_n20), .ex_wa(ex_wa0), .ex_we(ex_we0),
        .occ(occ0)
    );

    // Reference: an in-order queue of raw entries, at most two deep.
    ent_t mq[$];
    bit   live = 1'b0;

    always @(posedge clk) begin
        if (rst) begin
            mq.delete();
            live = 1'b1;
        end else if (flush) begin
            mq.delete();
        end else begin
            bit can_take;
            can_take = (mq.size() < 2);
            if (mq.size() > 0 && ex_ready) void'(mq.pop_front());
            if (id_valid && can_take && id_t != 7'd0)
                mq.push_back('{id_t, id_st, id_sst, id_n1, id_n2, id_wa, id_we});
        end
    end

    function automatic ent_t expect_out(input bit zx0);
        ent_t e;
        e = '0;
        if (mq.size() > 0) begin
            e = mq[0];
            if (zx0 && e.wa == 5'd0) e.we = 1'b0;
        end
        return e;
    endfunction

    always @(negedge clk) begin
        if (live) begin
            logic [3:0] exp_ctl, act_ctl, act_ctl0;
            ent_t e1, e0, a1, a0;
            exp_ctl  = {mq.size() < 2, mq.size() > 0, 2'(mq.size())};
            act_ctl  = {id_ready, ex_valid, occ};
            act_ctl0 = {id_ready0, ex_valid0, occ0};
            e1 = expect_out(1'b1);
            e0 = expect_out(1'b0);
            a1 = {ex_t, ex_st, ex_sst, ex_n1, ex_n2, ex_wa, ex_we};
            a0 = {ex_t0, ex_st0, ex_sst0, ex_n10, ex_n20, ex_wa0, ex_we0};
            checks += 4;
            if (act_ctl !== exp_ctl) begin
                failures++;
                $display("FAIL ctl t=%0t act=%h exp=%h", $time, act_ctl, exp_ctl);
            end
            if (act_ctl0 !== exp_ctl) begin
                failures++;
                $display("FAIL ctl0 t=%0t act=%h exp=%h", $time, act_ctl0, exp_ctl);
            end
            if (a1 !== e1) begin
                failures++;
                $display("FAIL payload t=%0t act=%h exp=%h", $time, a1, e1);
            end
            if (a0 !== e0) begin
                failures++;
                $display("FAIL payload0 t=%0t act=%h exp=%h", $time, a0, e0);
            end
        end
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s act=%h exp=%h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic [6:0] t, input logic [31:0] n1,
                         input logic [31:0] n2, input logic [4:0] wa, input logic we);
        id_valid = v;
        id_t     = t;
        id_n1    = n1;
        id_n2    = n2;
        id_wa    = wa;
        id_we    = we;
        id_st    = 3'd0;
        id_sst   = 1'b0;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        drive(1'b0, 7'd0, 0, 0, 0, 1'b0);
        flush = 1'b0;
        step();
        rst = 1'b0;
    endtask

    initial begin
        do_reset();
        step();
        chk("reset_occ", occ, 0);
        chk("reset_valid", ex_valid, 0);
        chk("reset_ready", id_ready, 1);
        chk("reset_t", ex_t, 0);

        // Streaming
        ex_ready = 1'b1;
        drive(1'b1, 7'h33, 32'd5, 32'd7, 5'd3, 1'b1);
        step();
        chk("stream1_t", ex_t, 7'h33);
        chk("stream1_n1", ex_n1, 5);
        chk("stream1_n2", ex_n2, 7);
        chk("stream1_occ", occ, 1);
        drive(1'b1, 7'h13, 32'd9, 32'd7, 5'd3, 1'b1);
        step();
        chk("stream2_t", ex_t, 7'h13);
        chk("stream2_n1", ex_n1, 9);
        chk("stream2_valid", ex_valid, 1);
        chk("stream2_occ", occ, 1);
        drive(1'b0, 7'd0, 0, 0, 0, 1'b0);
        step();
        chk("stream_drain", ex_valid, 0);

        // Backpressure
        ex_ready = 1'b0;
        drive(1'b1, 7'h33, 32'd1, 32'd0, 5'd1, 1'b1);
        step();
        drive(1'b1, 7'h13, 32'd2, 32'd0, 5'd1, 1'b1);
        step();
        chk("bp_ready_low", id_ready, 0);
        drive(1'b1, 7'h03, 32'd3, 32'd0, 5'd1, 1'b1);
        step();
        chk("bp_occ", occ, 2);
        chk("bp_hold_t", ex_t, 7'h33);
        ex_ready = 1'b1;
        step();
        chk("bp_out2", ex_t, 7'h13);
        step();
        chk("bp_out3", ex_t, 7'h03);
        drive(1'b0, 7'd0, 0, 0, 0, 1'b0);
        step();
        chk("bp_empty", occ, 0);

        // Bubble
        drive(1'b1, 7'd0, 32'hFFFF_FFFF, 0, 5'd2, 1'b1);
        step();
        chk("bubble_ready", id_ready, 1);
        chk("bubble_occ", occ, 0);
        chk("bubble_valid", ex_valid, 0);
        chk("bubble_n1", ex_n1, 0);

        // x0 write-enable suppression
        ex_ready = 1'b0;
        drive(1'b1, 7'h33, 32'd4, 32'd4, 5'd0, 1'b1);
        step();
        chk("x0_we_suppressed", ex_we, 0);
        chk("x0_we_kept", ex_we0, 1);

        // Flush while full with a simultaneous input
        drive(1'b1, 7'h13, 32'd6, 32'd6, 5'd2, 1'b1);
        step();
        chk("fl_pre_occ", occ, 2);
        drive(1'b1, 7'h63, 32'd8, 32'd8, 5'd4, 1'b1);
        flush = 1'b1;
        ex_ready = 1'b1;
        step();
        flush = 1'b0;
        drive(1'b0, 7'd0, 0, 0, 0, 1'b0);
        chk("fl_occ", occ, 0);
        chk("fl_valid", ex_valid, 0);
        chk("fl_t", ex_t, 0);
        chk("fl_n1", ex_n1, 0);
        step();
        chk("fl_no63", ex_t, 0);

        // Flush from ONE kills an acceptable input too
        drive(1'b1, 7'h33, 32'd1, 32'd1, 5'd1, 1'b1);
        ex_ready = 1'b0;
        step();
        drive(1'b1, 7'h63, 32'd2, 32'd2, 5'd1, 1'b1);
        flush = 1'b1;
        step();
        flush = 1'b0;
        drive(1'b0, 7'd0, 0, 0, 0, 1'b0);
        chk("fl1_occ", occ, 0);
        step();
        chk("fl1_no63", ex_valid, 0);

        // Reset mid-stall
        drive(1'b1, 7'h33, 32'd1, 32'd1, 5'd1, 1'b1);
        step();
        drive(1'b1, 7'h13, 32'd2, 32'd2, 5'd1, 1'b1);
        step();
        chk("rs_pre_occ", occ, 2);
        rst = 1'b1;
        step();
        rst = 1'b0;
        drive(1'b0, 7'd0, 0, 0, 0, 1'b0);
        chk("rs_occ", occ, 0);
        chk("rs_valid", ex_valid, 0);
        chk("rs_t", ex_t, 0);
        chk("rs_ready", id_ready, 1);

        // Random traffic, checked each cycle by the compare process
        for (int i = 0; i < 3000; i++) begin
            id_valid = ($urandom_range(0, 3) != 0);
            id_t     = ($urandom_range(0, 4) == 0) ? 7'd0 : 7'($urandom_range(1, 127));
            id_st    = 3'($urandom_range(0, 7));
            id_sst   = 1'($urandom_range(0, 1));
            id_n1    = $urandom;
            id_n2    = $urandom;
            id_wa    = ($urandom_range(0, 2) == 0) ? 5'd0 : 5'($urandom_range(0, 31));
            id_we    = 1'($urandom_range(0, 1));
            ex_ready = ($urandom_range(0, 2) != 0);
            flush    = ($urandom_range(0, 29) == 0);
            rst      = ($urandom_range(0, 199) == 0);
            step();
        end
        rst = 1'b0;
        flush = 1'b0;
        step();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
